// File: rtl/vector_issue_scheduler.sv
// Vector op scheduler: queues decoded ops, launches one at a time on vfu_execute, returns results tagged.
// Latency: push N -> pop N+1 -> vfu_execute N+2; wb_valid the cycle after FINISHED (N+2 for zero-length).
// Backpressure: req_ready = !full; wb_* held until wb_ready. `VEC_SCHED_PERF_EN adds perf_issued/perf_stall.

module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module vector_issue_scheduler #(
  parameter int LEN           = 32,
  parameter int VECTOR_SIZE   = 8,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int TAG_WIDTH     = 4,
  parameter int DEPTH         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [PAYLOAD_WIDTH-1:0]    req_payload,
  input  logic [LEN-1:0]              req_length,
  input  logic [TAG_WIDTH-1:0]        req_tag,
  output logic                        vfu_execute,
  output logic [PAYLOAD_WIDTH-1:0]    vfu_payload,
  output logic [LEN-1:0]              vfu_length,
  input  logic [1:0]                  vfu_status,
  input  logic [VECTOR_SIZE*LEN-1:0]  vfu_result,
  input  logic                        vfu_is_mask,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [TAG_WIDTH-1:0]        wb_tag,
  output logic [VECTOR_SIZE*LEN-1:0]  wb_result,
  output logic                        wb_is_mask,
  output logic                        err
`ifdef VEC_SCHED_PERF_EN
  ,
  output logic [LEN-1:0]              perf_issued,
  output logic [LEN-1:0]              perf_stall
`endif
);
  localparam logic [1:0] VEC_ALU_NOP      = 2'd0;
  localparam logic [1:0] VEC_ALU_WORKING  = 2'd1;
  localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WB} state_t;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [LEN-1:0]           length;
    logic [TAG_WIDTH-1:0]     tag;
  } req_t;

  state_t state_q, state_d;
  req_t   push_dat, head;
  logic   full, empty, push, pop;
  logic   head_zero, head_clamp, vfu_idle, wait_first;

  assign req_ready  = !full;
  assign push       = req_valid && req_ready && !flush;
  assign push_dat   = {req_payload, req_length, req_tag};
  assign head_zero  = (head.length == '0);
  assign head_clamp = (head.length > LEN'(VECTOR_SIZE));
  // A VFU still WORKING while we sit in IDLE can only be a flushed op draining out.
  assign vfu_idle   = (vfu_status == VEC_ALU_NOP) || (vfu_status == VEC_ALU_FINISHED);

  sched_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && vfu_idle) begin
            pop     = 1'b1;
            state_d = head_zero ? WB : ISSUE;
          end
        end
        ISSUE:     state_d = WAIT_DONE;
        WAIT_DONE: if (vfu_status == VEC_ALU_FINISHED) state_d = WB;
        WB:        if (wb_ready) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vfu_execute <= 1'b0;
      vfu_payload <= '0;
      vfu_length  <= '0;
      wb_valid    <= 1'b0;
      wb_tag      <= '0;
      wb_result   <= '0;
      wb_is_mask  <= 1'b0;
      err         <= 1'b0;
      wait_first  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vfu_execute <= (state_d == ISSUE);
      wb_valid    <= (state_d == WB);
      wait_first  <= (state_q == ISSUE) && (state_d == WAIT_DONE);
      if (pop) begin
        wb_tag <= head.tag;
        if (head_zero) begin
          wb_result  <= '0;
          wb_is_mask <= 1'b0;
        end else begin
          vfu_payload <= head.payload;
          vfu_length  <= head_clamp ? LEN'(VECTOR_SIZE) : head.length;
        end
        if (head_clamp) err <= 1'b1;
      end
      if (!flush && state_q == WAIT_DONE) begin
        // The VFU must acknowledge a launch by reporting WORKING on the very next cycle.
        if (wait_first && vfu_status != VEC_ALU_WORKING) err <= 1'b1;
        if (vfu_status == VEC_ALU_FINISHED) begin
          wb_result  <= vfu_result;
          wb_is_mask <= vfu_is_mask;
        end
      end
    end
  end

`ifdef VEC_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (vfu_execute) perf_issued <= perf_issued + 1'b1;
      if ((state_q == WB && !wb_ready) || (state_q == IDLE && !empty && !vfu_idle))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Bench for vector_issue_scheduler: behavioural VFU, queue scoreboard, directed then randomized ops.
`timescale 1ns/1ps
module tb_vector_issue_scheduler;
  localparam int LEN = 32, VS = 8, PW = 128, TW = 4, DEPTH = 4, RW = VS * LEN;
  localparam logic [1:0] NOP = 2'd0, WORKING = 2'd1, FINISHED = 2'd2;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, req_ready;
  logic [PW-1:0] req_payload, vfu_payload;
  logic [LEN-1:0] req_length, vfu_length;
  logic [TW-1:0] req_tag, wb_tag;
  logic          vfu_execute, vfu_is_mask, wb_valid, wb_ready, wb_is_mask, err;
  logic [1:0]    vfu_status;
  logic [RW-1:0] vfu_result, wb_result;
`ifdef VEC_SCHED_PERF_EN
  logic [LEN-1:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  vector_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .req_length(req_length), .req_tag(req_tag),
    .vfu_execute(vfu_execute), .vfu_payload(vfu_payload), .vfu_length(vfu_length),
    .vfu_status(vfu_status), .vfu_result(vfu_result), .vfu_is_mask(vfu_is_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_result(wb_result), .wb_is_mask(wb_is_mask), .err(err)
`ifdef VEC_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result the behavioural VFU produces: one word per active element.
  function automatic logic [RW-1:0] vfu_fn(input logic [PW-1:0] pl, input logic [LEN-1:0] len);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < VS; i++)
      if (i < len) r[i*32 +: 32] = (pl[31:0] ^ pl[127:96]) + 32'(i) * 32'h9e3779b9;
    return r;
  endfunction

  function automatic logic [PW-1:0] rpl();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural VFU: WORKING for vfu_busy_cfg cycles after execute, then FINISHED until relaunched.
  int vfu_busy_cfg = 4, vfu_cnt;
  bit vfu_stuck = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vfu_status <= NOP; vfu_cnt <= 0; vfu_result <= '0; vfu_is_mask <= 1'b0;
    end else if (vfu_execute && !vfu_stuck) begin
      vfu_status  <= WORKING;
      vfu_cnt     <= vfu_busy_cfg;
      vfu_result  <= vfu_fn(vfu_payload, vfu_length);
      vfu_is_mask <= vfu_payload[5];
    end else if (vfu_status == WORKING) begin
      if (vfu_cnt <= 1) vfu_status <= FINISHED;
      else vfu_cnt <= vfu_cnt - 1;
    end
  end

  // Scoreboard: every accepted request must come back once, in order, unless flushed or reset.
  typedef struct { logic [TW-1:0] tag; logic [RW-1:0] res; logic mask; } exp_t;
  exp_t exp_q[$];
  int   exec_cnt = 0, exec_since_rst = 0, wb_cnt = 0;
  bit   prev_exec = 0, prev_working = 0, prev_hold = 0;
  logic [TW-1:0] prev_tag;
  logic [RW-1:0] prev_res;
  logic          prev_mask;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete(); exec_since_rst = 0;
      prev_exec = 0; prev_working = 0; prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("wb_hold_valid", wb_valid, 1'b1);
        check("wb_hold_tag", wb_tag, prev_tag);
        check("wb_hold_result", wb_result, prev_res);
        check("wb_hold_mask", wb_is_mask, prev_mask);
      end
      if (vfu_execute) begin
        exec_cnt++; exec_since_rst++;
        check("exec_while_vfu_working", prev_working, 1'b0);
        check("exec_single_cycle", prev_exec, 1'b0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (wb_valid && wb_ready) begin
          wb_cnt++;
          check("wb_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_tag", wb_tag, e.tag);
            check("wb_result", wb_result, e.res);
            check("wb_is_mask", wb_is_mask, e.mask);
          end
        end
        if (req_valid && req_ready) begin
          exp_t e;
          logic [LEN-1:0] l;
          l = (req_length > VS) ? LEN'(VS) : req_length;
          e.tag  = req_tag;
          e.res  = (l == 0) ? '0 : vfu_fn(req_payload, l);
          e.mask = (l == 0) ? 1'b0 : req_payload[5];
          exp_q.push_back(e);
        end
      end
      prev_exec    = vfu_execute;
      prev_working = (vfu_status == WORKING);
      prev_hold    = wb_valid && !wb_ready && !flush;
      prev_tag = wb_tag; prev_res = wb_result; prev_mask = wb_is_mask;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [TW-1:0] tag, input logic [LEN-1:0] len, input logic [PW-1:0] pl);
    int n;
    n = 0;
    req_valid = 1'b1; req_tag = tag; req_length = len; req_payload = pl;
    while (!req_ready && n < 200) begin step(); n++; end
    check("push_accept_bound", n < 200, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_wb_valid(input int budget);
    int n;
    n = 0;
    while (!wb_valid && n < budget) begin step(); n++; end
    check("wb_valid_bound", n < budget, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb_valid) && n < budget) begin step(); n++; end
    check("drain_bound", n < budget, 1'b1);
  endtask

  initial begin
    int e0, w0, n;
    bit any_clamp, accepted;
    int sent;
    logic [PW-1:0] p;
    logic [1:0] st_prev;
`ifdef VEC_SCHED_PERF_EN
    logic [LEN-1:0] s0;
`endif
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_payload = '0; req_length = '0;
    req_tag = '0; wb_ready = 1'b1;
    step(); step();
    // Reset values
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_vfu_execute", vfu_execute, 1'b0);
    check("rst_vfu_payload", vfu_payload, '0);
    check("rst_vfu_length", vfu_length, '0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_tag", wb_tag, '0);
    check("rst_wb_result", wb_result, '0);
    check("rst_wb_is_mask", wb_is_mask, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    step();

    // Single op: tag 3, length 8, four WORKING cycles
    vfu_busy_cfg = 4; e0 = exec_cnt; w0 = wb_cnt;
    p = rpl();
    push(4'd3, 32'd8, p);
    check("single_no_exec_n1", vfu_execute, 1'b0);
    step();
    check("single_exec_n2", vfu_execute, 1'b1);
    check("single_vfu_length", vfu_length, 32'd8);
    check("single_vfu_payload", vfu_payload, p);
    n = 0;
    while (!wb_valid && n < 50) begin st_prev = vfu_status; step(); n++; end
    check("single_wb_latency", n, 6);
    check("single_finished_before_wb", st_prev, FINISHED);
    step(); step();
    check("single_exec_count", exec_cnt - e0, 1);
    check("single_wb_count", wb_cnt - w0, 1);
    check("single_wb_dropped", wb_valid, 1'b0);

    // Fill: five ops against a slow VFU, FIFO saturates after the fourth queued entry
    vfu_busy_cfg = 20; w0 = wb_cnt;
    for (int i = 0; i < 5; i++) begin
      push(4'(i), 32'(i + 1), rpl());
      if (i == 3) check("fill_ready_3_queued", req_ready, 1'b1);
    end
    check("fill_ready_full", req_ready, 1'b0);
    vfu_busy_cfg = 2;
    wait_drain(400);
    check("fill_wb_count", wb_cnt - w0, 5);
    check("fill_ready_after", req_ready, 1'b1);

    // Zero length: written back two cycles after push, VFU untouched
    e0 = exec_cnt;
    push(4'd7, 32'd0, rpl());
    check("zero_wb_n1", wb_valid, 1'b0);
    step();
    check("zero_wb_n2", wb_valid, 1'b1);
    check("zero_wb_tag", wb_tag, 4'd7);
    check("zero_wb_result", wb_result, '0);
    step(); step();
    check("zero_no_exec", exec_cnt - e0, 0);

    // Backpressure: hold wb_ready low for 10 cycles with another op queued
    wb_ready = 1'b0; vfu_busy_cfg = 3;
    push(4'd5, 32'd4, rpl());
    push(4'd6, 32'd2, rpl());
    wait_wb_valid(50);
`ifdef VEC_SCHED_PERF_EN
    s0 = perf_stall;
`endif
    for (int i = 0; i < 10; i++) begin
      check("bp_no_exec", vfu_execute, 1'b0);
      step();
    end
`ifdef VEC_SCHED_PERF_EN
    check("bp_perf_stall", perf_stall, s0 + 32'd10);
`endif
    check("bp_tag_still_5", wb_tag, 4'd5);
    wb_ready = 1'b1;
    wait_drain(100);
    check("err_clean_so_far", err, 1'b0);

    // Randomized traffic with random writeback backpressure and VFU latency
    sent = 0; any_clamp = 0; w0 = wb_cnt; n = 0;
    while ((sent < 40 || exp_q.size() != 0 || wb_valid) && n < 5000) begin
      if (!req_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
        req_tag = 4'($urandom); req_length = 32'($urandom_range(0, 12)); req_payload = rpl();
        req_valid = 1'b1;
        if (req_length > VS) any_clamp = 1;
      end
      wb_ready = ($urandom_range(0, 3) != 0);
      vfu_busy_cfg = $urandom_range(1, 5);
      accepted = req_valid && req_ready;
      step();
      if (accepted) begin req_valid = 1'b0; sent++; end
      n++;
    end
    check("rand_bound", n < 5000, 1'b1);
    check("rand_wb_count", wb_cnt - w0, 40);
    check("rand_err", err, any_clamp);
    wb_ready = 1'b1;

    // Reset asserted mid-operation
    vfu_busy_cfg = 5;
    push(4'd1, 32'd5, rpl());
    step(); step();
    rst = 1'b0; #1;
    check("midrst_wb_valid", wb_valid, 1'b0);
    check("midrst_exec", vfu_execute, 1'b0);
    check("midrst_vfu_length", vfu_length, '0);
    check("midrst_err", err, 1'b0);
    check("midrst_ready", req_ready, 1'b1);
    step();
    rst = 1'b1;
    step();

    // Protocol error: VFU ignores execute and stays NOP
    vfu_stuck = 1;
    push(4'd4, 32'd3, rpl());
    check("nop_err_before", err, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("nop_err_set", err, 1'b1);
    check("nop_no_wb", wb_valid, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    vfu_stuck = 0;
    step(); step();
    check("nop_err_sticky", err, 1'b1);

    // Flush during WAIT_DONE with two queued ops, then issue waits for the VFU to drain
    vfu_busy_cfg = 12; w0 = wb_cnt;
    push(4'd10, 32'd4, rpl());
    push(4'd11, 32'd3, rpl());
    push(4'd12, 32'd2, rpl());
    check("flush_vfu_working", vfu_status, WORKING);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_wb_low", wb_valid, 1'b0);
    check("flush_ready", req_ready, 1'b1);
    vfu_busy_cfg = 2;
    check("flush_push_while_working", vfu_status, WORKING);
    push(4'd9, 32'd2, rpl());
    n = 0; st_prev = vfu_status;
    while (!vfu_execute && n < 100) begin st_prev = vfu_status; step(); n++; end
    check("flush_exec_bound", n < 100, 1'b1);
    check("flush_issue_after_finish", st_prev, FINISHED);
    wait_drain(100);
    for (int i = 0; i < 5; i++) step();
    check("flush_wb_count", wb_cnt - w0, 1);

    // Length clamp on a clean error flag
    rst = 1'b0; step(); rst = 1'b1; step();
    check("clamp_err_before", err, 1'b0);
    vfu_busy_cfg = 2;
    push(4'd2, 32'd20, rpl());
    n = 0;
    while (!vfu_execute && n < 20) begin step(); n++; end
    check("clamp_exec_bound", n < 20, 1'b1);
    check("clamp_vfu_length", vfu_length, 32'd8);
    step();
    check("clamp_err", err, 1'b1);
    wait_drain(50);
`ifdef VEC_SCHED_PERF_EN
    check("perf_issued", perf_issued, 32'(exec_since_rst));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
